// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration helpers for the stopwatch control sequencer.
package stopwatch_pkg;

    // Mode FSM states; the encodings are visible on the state port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    // Clock cycles per count-enable tick; CLK_HZ must be an integer multiple
    // of TICK_HZ giving at least 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, stability counter and a one-cycle
// press pulse on each accepted rising level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; pulse press in the same edge that a high level is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_b;
                    cnt   <= '0;
                    press <= sync_b;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                // Any agreeing sample restarts the stability window.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced buttons drive the mode FSM, which
// gates the centisecond prescaler and issues the counter clear and lap freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       tick,
    output logic       clr,
    output logic       lap_hold,
    output logic       running,
    output logic [1:0] state
);

    localparam int            DIV        = calc_div(CLK_HZ, TICK_HZ);
    localparam int            PW         = calc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic          ss_p;
    logic          lap_p;
    logic          clr_p;
    state_t        state_q;
    logic [PW-1:0] presc;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start_stop),
        .press (ss_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clr_p)
    );

    assign state = state_q;

    // Mode FSM and prescaler with registered tick/clr/lap_hold/running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            presc    <= '0;
            tick     <= 1'b0;
            clr      <= 1'b0;
            lap_hold <= 1'b0;
            running  <= 1'b0;
        end else begin
            tick <= 1'b0;
            clr  <= 1'b0;

            // Every cycle spent in RUNNING/LAP advances the prescaler, so a
            // pause/resume keeps the partial period. A start/stop press is the
            // only way out of these states; when it lands on the wrap cycle the
            // tick is withheld and the count stays at DIV-1 so the tick is
            // issued on the first cycle after resuming.
            if (state_q == RUNNING || state_q == LAP) begin
                if (presc == PRESC_LAST) begin
                    if (!ss_p) begin
                        presc <= '0;
                        tick  <= 1'b1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            // Priority clear > start/stop > lap; a press ignored in the current
            // state falls through to the next one.
            case (state_q)
                IDLE: begin
                    if (clr_p) begin
                        clr <= 1'b1;
                    end else if (ss_p) begin
                        state_q <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (ss_p) begin
                        state_q <= PAUSED;
                        running <= 1'b0;
                    end else if (lap_p) begin
                        state_q  <= LAP;
                        lap_hold <= 1'b1;
                    end
                end
                LAP: begin
                    if (ss_p) begin
                        state_q  <= PAUSED;
                        running  <= 1'b0;
                        lap_hold <= 1'b0;
                    end else if (lap_p) begin
                        state_q  <= RUNNING;
                        lap_hold <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (clr_p) begin
                        state_q <= IDLE;
                        clr     <= 1'b1;
                        presc   <= '0;
                    end else if (ss_p) begin
                        state_q <= RUNNING;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    running  <= 1'b0;
                    lap_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-cycle debounce.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEB     = 4;
    localparam int L       = DEB + 3;   // raw high -> state change, in cycles
    localparam int DIV     = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       b_ss = 1'b0;
    logic       b_lap = 1'b0;
    logic       b_clr = 1'b0;
    logic       tick;
    logic       clr;
    logic       lap_hold;
    logic       running;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tick_q[$];
    int clr_q[$];
    int trans = 0;
    logic [1:0] prev_state = 2'd0;
    int e0, t, r, s, bad, err;

    always #5 clk = ~clk;

    // Count rising edges; at a falling edge cyc names the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    stopwatch_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .TICK_HZ         (TICK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (b_ss),
        .btn_lap        (b_lap),
        .btn_clear      (b_clr),
        .tick           (tick),
        .clr            (clr),
        .lap_hold       (lap_hold),
        .running        (running),
        .state          (state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance n falling edges, logging ticks, clears and state changes.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tick === 1'b1) tick_q.push_back(cyc);
            if (clr === 1'b1)  clr_q.push_back(cyc);
            if (state !== prev_state) trans++;
            prev_state = state;
        end
    endtask

    task automatic clear_log();
        tick_q.delete();
        clr_q.delete();
        trans = 0;
    endtask

    // Wait (bounded) for the next tick; returns its cycle number.
    task automatic wait_tick(output int tc);
        bit found;
        found = 1'b0;
        tc = 0;
        for (int i = 0; i < 25 && !found; i++) begin
            cycles(1);
            if (tick === 1'b1) begin
                found = 1'b1;
                tc = cyc;
            end
        end
        if (!found) begin
            check("tick_wait", 0, 1);
            tc = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset and first start
        cycles(3);
        check("rst_state", state, 0);
        check("rst_outs", {tick, clr, lap_hold, running}, 0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (state !== 2'd0 || tick !== 1'b0 || clr !== 1'b0 ||
                lap_hold !== 1'b0 || running !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        b_ss = 1'b1;
        cycles(L - 1);
        check("ss_lat_before", state, 0);
        cycles(1);
        check("ss_lat_state", state, 1);
        check("ss_running", running, 1);
        e0 = cyc;
        b_ss = 1'b0;
        clear_log();
        cycles(35);
        check("t1_nticks", tick_q.size(), 3);
        for (int k = 0; k < 3; k++)
            if (tick_q.size() > k) check($sformatf("t1_tick%0d", k), tick_q[k], e0 + DIV * (k + 1));

        // 2. Bounce rejection, then a clean hold
        clear_log();
        for (int p = 0; p < 5; p++) begin
            b_ss = 1'b1;
            cycles(3);
            b_ss = 1'b0;
            cycles(3);
        end
        cycles(10);
        check("bounce_state", state, 1);
        check("bounce_trans", trans, 0);
        clear_log();
        b_ss = 1'b1;
        cycles(10);
        b_ss = 1'b0;
        cycles(20);
        check("hold_trans", trans, 1);
        check("hold_state", state, 2);

        // 3. Pause 6 cycles after a tick preserves the partial period
        b_ss = 1'b1;
        cycles(L);
        b_ss = 1'b0;
        check("resume1_state", state, 1);
        wait_tick(t);
        cycles(9);
        b_ss = 1'b1;
        clear_log();
        cycles(1);
        check("pre_pause_tick", tick, 1);
        cycles(5);
        check("pause_before", state, 1);
        cycles(1);
        check("pause_state", state, 2);
        b_ss = 1'b0;
        clear_log();
        cycles(50);
        check("paused_no_tick", tick_q.size(), 0);
        check("paused_state", state, 2);
        b_ss = 1'b1;
        cycles(L);
        check("resume2_state", state, 1);
        r = cyc;
        b_ss = 1'b0;
        clear_log();
        cycles(16);
        check("resume_nticks", tick_q.size(), 2);
        if (tick_q.size() > 0) check("resume_first", tick_q[0], r + 4);
        if (tick_q.size() > 1) check("resume_second", tick_q[1], r + 14);

        // 4. Lap freeze
        b_lap = 1'b1;
        cycles(L);
        b_lap = 1'b0;
        check("lap_state", state, 3);
        check("lap_hold_on", lap_hold, 1);
        check("lap_running", running, 1);
        clear_log();
        cycles(40);
        check("lap_nticks", tick_q.size(), 4);
        err = 0;
        foreach (tick_q[k]) if ((tick_q[k] - (r + 4)) % DIV != 0) err++;
        check("lap_tick_phase", err, 0);
        check("lap_hold_kept", lap_hold, 1);
        b_lap = 1'b1;
        cycles(L);
        b_lap = 1'b0;
        check("unlap_state", state, 1);
        check("unlap_hold", lap_hold, 0);
        check("unlap_running", running, 1);
        cycles(10);

        // 5. Clear rules
        clear_log();
        b_clr = 1'b1;
        cycles(20);
        b_clr = 1'b0;
        check("clr_run_ignored", clr_q.size(), 0);
        check("clr_run_state", state, 1);
        cycles(10);
        wait_tick(t);
        clear_log();
        b_clr = 1'b1;
        b_ss = 1'b1;
        cycles(L);
        check("clr_ss_state", state, 2);
        check("clr_ss_noclr", clr_q.size(), 0);
        b_clr = 1'b0;
        b_ss = 1'b0;
        cycles(10);
        clear_log();
        b_clr = 1'b1;
        cycles(L);
        check("clr_pause_state", state, 0);
        check("clr_pulse_hi", clr, 1);
        cycles(1);
        check("clr_pulse_lo", clr, 0);
        check("clr_count", clr_q.size(), 1);
        check("clr_running", running, 0);
        b_clr = 1'b0;
        cycles(10);
        b_ss = 1'b1;
        cycles(L);
        check("restart_state", state, 1);
        s = cyc;
        b_ss = 1'b0;
        clear_log();
        cycles(12);
        check("restart_nticks", tick_q.size(), 1);
        if (tick_q.size() > 0) check("restart_first", tick_q[0], s + DIV);

        // 6. Asynchronous reset while in LAP
        b_lap = 1'b1;
        cycles(L);
        b_lap = 1'b0;
        check("lap2_state", state, 3);
        cycles(3);
        #2;
        reset = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_lap_hold", lap_hold, 0);
        check("async_running", running, 0);
        cycles(3);
        reset = 1'b1;
        clear_log();
        cycles(30);
        check("post_rst_no_tick", tick_q.size(), 0);
        check("post_rst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
